// File: rtl/attn_query_sched_if.sv
// Datapath-side bus of the attention query scheduler: the request pulse,
// the current query, the batch keys, and the result strobe with its winner.
interface attn_query_sched_if #(
  parameter int WIDTH = 8
);
  logic             dp_valid_in;
  logic [WIDTH-1:0] dp_q;
  logic [WIDTH-1:0] dp_k0;
  logic [WIDTH-1:0] dp_k1;
  logic [WIDTH-1:0] dp_k2;
  logic [WIDTH-1:0] dp_k3;
  logic             dp_valid_out;
  logic [1:0]       dp_winner;

  // Scheduler side: issues requests, consumes results.
  modport master (
    output dp_valid_in, dp_q, dp_k0, dp_k1, dp_k2, dp_k3,
    input  dp_valid_out, dp_winner
  );

  // Datapath side: consumes requests, produces results.
  modport slave (
    input  dp_valid_in, dp_q, dp_k0, dp_k1, dp_k2, dp_k3,
    output dp_valid_out, dp_winner
  );
endinterface

// File: rtl/attn_query_sched.sv
// Attention query scheduler: latches a batch of 4 queries and 4 keys, then
// issues the queries one at a time to a shared scoring datapath, collects a
// 2-bit winner per query (or a timeout flag), and pulses done at the end.
// Optional busy-cycle performance counter enabled by defining SCHED_PERF_EN.
module attn_query_sched #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     in_q0,
  input  logic [WIDTH-1:0]     in_q1,
  input  logic [WIDTH-1:0]     in_q2,
  input  logic [WIDTH-1:0]     in_q3,
  input  logic [WIDTH-1:0]     in_k0,
  input  logic [WIDTH-1:0]     in_k1,
  input  logic [WIDTH-1:0]     in_k2,
  input  logic [WIDTH-1:0]     in_k3,
  output logic                 busy,
  output logic                 done,
  output logic [7:0]           winner_map,
  output logic [3:0]           timeout_flags,
  output logic [15:0]          busy_cycles,
  attn_query_sched_if.master   dp
);

  localparam int N = 4;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q [N];
  logic [WIDTH-1:0] q_d [N];
  logic [WIDTH-1:0] k_q [N];
  logic [WIDTH-1:0] k_d [N];
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             valid_in_q, valid_in_d;
  logic [7:0]       winner_map_q, winner_map_d;
  logic [3:0]       flags_q, flags_d;
  logic             advance;

  // Next-state and next-output computation for the batch sequencer.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    q_d          = q_q;
    k_d          = k_q;
    winner_map_d = winner_map_q;
    flags_d      = flags_q;
    advance      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          q_d          = '{in_q0, in_q1, in_q2, in_q3};
          k_d          = '{in_k0, in_k1, in_k2, in_k3};
          winner_map_d = '0;
          flags_d      = '0;
          idx_d        = '0;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A result arriving on the last allowed cycle beats the timeout.
        if (dp.dp_valid_out) begin
          winner_map_d[{idx_q, 1'b0} +: 2] = dp.dp_winner;
          advance = 1'b1;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          winner_map_d[{idx_q, 1'b0} +: 2] = 2'b00;
          flags_d[idx_q] = 1'b1;
          advance = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
        if (advance) begin
          if (idx_q == 2'(N - 1)) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = S_ISSUE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they are registered.
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
    valid_in_d = (state_d == S_ISSUE);
  end

  // State, batch registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      // NOTE: the query/key arrays are real flops that must read zero after
      // reset, so they are cleared here rather than left as unreset storage.
      for (int i = 0; i < N; i++) begin
        q_q[i] <= '0;
        k_q[i] <= '0;
      end
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      valid_in_q   <= 1'b0;
      winner_map_q <= '0;
      flags_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      q_q          <= q_d;
      k_q          <= k_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      valid_in_q   <= valid_in_d;
      winner_map_q <= winner_map_d;
      flags_q      <= flags_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign winner_map     = winner_map_q;
  assign timeout_flags  = flags_q;
  assign dp.dp_valid_in = valid_in_q;
  assign dp.dp_q        = q_q[idx_q];
  assign dp.dp_k0       = k_q[0];
  assign dp.dp_k1       = k_q[1];
  assign dp.dp_k2       = k_q[2];
  assign dp.dp_k3       = k_q[3];

`ifdef SCHED_PERF_EN
  logic [15:0] busy_cycles_q, busy_cycles_d;

  // Saturating count of busy cycles, restarted by each accepted batch.
  always_comb begin
    busy_cycles_d = busy_cycles_q;
    if (state_q == S_IDLE && start) begin
      busy_cycles_d = '0;
    end else if (busy_q && busy_cycles_q != 16'hFFFF) begin
      busy_cycles_d = busy_cycles_q + 16'd1;
    end
  end

  // Busy-cycle counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_cycles_q <= '0;
    else        busy_cycles_q <= busy_cycles_d;
  end

  assign busy_cycles = busy_cycles_q;
`else
  assign busy_cycles = 16'h0000;
`endif

endmodule
